// File: rtl/alu_acumulador_seq.sv
// alu_acumulador_seq: clocked ALU with accumulator, start/busy/done handshake, shift-add multiply.
// Define ALU_SAT_EN to make ADD, SUB and ACC_ADD saturate instead of wrapping.
module alu_acumulador_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   C,
    output logic                 carry,
    output logic                 zero,
    output logic [WIDTH-1:0]     acumulador,
    output logic                 busy,
    output logic                 done
);
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL_ITER} state_t;
    state_t state, state_nx;

    logic [2:0]         op;
    logic [WIDTH-1:0]   opa, opb;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, prod, mul_sum, res;
    logic [WIDTH:0]     sum, diff, acc_sum;
    logic [WIDTH-1:0]   acc_nx;
    logic               cy;

    assign busy    = state != IDLE;
    assign sum     = {1'b0, opa} + {1'b0, opb};
    assign diff    = {1'b0, opa} - {1'b0, opb};
    assign acc_sum = {1'b0, acumulador} + {1'b0, opa};
    // opb is shifted right each iteration, so bit 0 is always the current multiplier bit
    assign mul_sum = prod + (opb[0] ? mcand : '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? (sel == 3'b101 ? MUL_ITER : EXEC) : IDLE;
            EXEC:     state_nx = IDLE;
            MUL_ITER: state_nx = cnt == LAST ? IDLE : MUL_ITER;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        res    = '0;
        cy     = 1'b0;
        acc_nx = acumulador;
        case (op)
            3'b000: begin
                res = (SAT && sum[WIDTH]) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {{(WIDTH-1){1'b0}}, sum};
                cy  = sum[WIDTH];
            end
            3'b001: begin
                res = (SAT && diff[WIDTH]) ? '0 : {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                cy  = diff[WIDTH];
            end
            3'b010: res = {{WIDTH{1'b0}}, opa & opb};
            3'b011: res = {{WIDTH{1'b0}}, opa | opb};
            3'b100: res = {{WIDTH{1'b0}}, opa ^ opb};
            3'b110: begin
                acc_nx = (SAT && acc_sum[WIDTH]) ? {WIDTH{1'b1}} : acc_sum[WIDTH-1:0];
                res    = {{WIDTH{1'b0}}, acc_nx};
                cy     = acc_sum[WIDTH];
            end
            3'b111: acc_nx = '0;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            opa        <= '0;
            opb        <= '0;
            cnt        <= '0;
            mcand      <= '0;
            prod       <= '0;
            C          <= '0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            acumulador <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                op    <= sel;
                opa   <= A;
                opb   <= B;
                mcand <= {{WIDTH{1'b0}}, A};
                prod  <= '0;
                cnt   <= '0;
            end
            if (state == EXEC) begin
                C          <= res;
                carry      <= cy;
                zero       <= res == '0;
                acumulador <= acc_nx;
                done       <= 1'b1;
            end
            if (state == MUL_ITER) begin
                prod  <= mul_sum;
                mcand <= mcand << 1;
                opb   <= opb >> 1;
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    C     <= mul_sum;
                    carry <= 1'b0;
                    zero  <= mul_sum == '0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_acumulador_seq.sv
// tb_alu_acumulador_seq: directed vector table for single-cycle ops plus hand sequences for MUL and reset.
module tb_alu_acumulador_seq;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     sel = '0;
    logic [W-1:0]   A = '0, B = '0;
    logic [2*W-1:0] C;
    logic           carry, zero, busy, done;
    logic [W-1:0]   acumulador;

    int n_chk = 0;
    int n_fail = 0;

    alu_acumulador_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .A(A), .B(B),
        .C(C), .carry(carry), .zero(zero), .acumulador(acumulador), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     sel;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] c;
        logic           cy, z;
        logic [W-1:0]   acc;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, " C"}, 32'(C), 0);
        chk({nm, " carry"}, 32'(carry), 0);
        chk({nm, " zero"}, 32'(zero), 0);
        chk({nm, " acc"}, 32'(acumulador), 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " done"}, 32'(done), 0);
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp,
                          input logic [W-1:0] acc, input bit poke);
        @(negedge clk);
        start = 1'b1; sel = 3'b101; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        chk("mul busy after accept", 32'(busy), 1);
        for (int i = 1; i < W; i++) begin
            if (poke && i == 2) begin
                start = 1'b1; sel = 3'b000; A = 8'd1; B = 8'd1;
            end
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("mul busy cyc%0d", i), 32'(busy), 1);
            chk($sformatf("mul done early cyc%0d", i), 32'(done), 0);
        end
        @(negedge clk);
        chk("mul C", 32'(C), 32'(exp));
        chk("mul carry", 32'(carry), 0);
        chk("mul zero", 32'(zero), 32'(exp == 0));
        chk("mul done", 32'(done), 1);
        chk("mul busy end", 32'(busy), 0);
        chk("mul acc kept", 32'(acumulador), 32'(acc));
        repeat (3) begin
            @(negedge clk);
            chk("mul no second done", 32'(done), 0);
            chk("mul no queued busy", 32'(busy), 0);
        end
    endtask

    initial begin
        logic [W-1:0] acc_fin;
        acc_fin = SAT ? 8'd255 : 8'd44;
        v[0]  = '{3'b111, 8'd0,   8'd0,   16'd0,   1'b0, 1'b1, 8'd0};
        v[1]  = '{3'b110, 8'd100, 8'd0,   16'd100, 1'b0, 1'b0, 8'd100};
        v[2]  = '{3'b110, 8'd100, 8'd0,   16'd200, 1'b0, 1'b0, 8'd200};
        v[3]  = '{3'b110, 8'd100, 8'd0,   16'(acc_fin), 1'b1, 1'b0, acc_fin};
        v[4]  = '{3'b000, 8'd25,  8'd10,  16'd35,  1'b0, 1'b0, acc_fin};
        v[5]  = '{3'b000, 8'd200, 8'd100, SAT ? 16'd255 : 16'd300, 1'b1, 1'b0, acc_fin};
        v[6]  = '{3'b001, 8'd30,  8'd15,  16'd15,  1'b0, 1'b0, acc_fin};
        v[7]  = '{3'b001, 8'd10,  8'd20,  SAT ? 16'd0 : 16'h00F6, 1'b1, SAT, acc_fin};
        v[8]  = '{3'b100, 8'h5A,  8'h5A,  16'd0,   1'b0, 1'b1, acc_fin};
        v[9]  = '{3'b010, 8'hF0,  8'h3C,  16'h30,  1'b0, 1'b0, acc_fin};
        v[10] = '{3'b011, 8'hF0,  8'h0F,  16'hFF,  1'b0, 1'b0, acc_fin};
        v[11] = '{3'b000, 8'd255, 8'd255, SAT ? 16'd255 : 16'd510, 1'b1, 1'b0, acc_fin};
        v[12] = '{3'b001, 8'd0,   8'd0,   16'd0,   1'b0, 1'b1, acc_fin};

        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            start = 1'b1; sel = v[i].sel; A = v[i].a; B = v[i].b;
            @(negedge clk);
            start = 1'b0; A = ~A; B = ~B;
            chk($sformatf("v%0d busy", i), 32'(busy), 1);
            chk($sformatf("v%0d done low", i), 32'(done), 0);
            @(negedge clk);
            chk($sformatf("v%0d C", i), 32'(C), 32'(v[i].c));
            chk($sformatf("v%0d carry", i), 32'(carry), 32'(v[i].cy));
            chk($sformatf("v%0d zero", i), 32'(zero), 32'(v[i].z));
            chk($sformatf("v%0d acc", i), 32'(acumulador), 32'(v[i].acc));
            chk($sformatf("v%0d done", i), 32'(done), 1);
            chk($sformatf("v%0d busy low", i), 32'(busy), 0);
        end
        @(negedge clk);
        chk("hold C", 32'(C), 0);
        chk("hold done", 32'(done), 0);

        do_mul(8'd200, 8'd250, 16'd50000, acc_fin, 1'b1);
        do_mul(8'd255, 8'd255, 16'd65025, acc_fin, 1'b0);
        do_mul(8'd3,   8'd0,   16'd0,     acc_fin, 1'b0);
        do_mul(8'd200, 8'd250, 16'd50000, acc_fin, 1'b0);

        @(negedge clk);
        start = 1'b1; sel = 3'b101; A = 8'd200; B = 8'd250;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            chk("abort no done", 32'(done), 0);
            chk("abort no busy", 32'(busy), 0);
        end
        start = 1'b1; sel = 3'b000; A = 8'd1; B = 8'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("post C", 32'(C), 2);
        chk("post carry", 32'(carry), 0);
        chk("post done", 32'(done), 1);
        chk("post acc", 32'(acumulador), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
